mux16b_8to1_sync: RTL and testbench
===================================

Name: mux16b_8to1_sync

Overview:
- 8-input, 16-bit-wide word multiplexer for the 16-bit single-cycle CPU datapath, e.g. selecting the writeback or ALU operand source.
- Provides a zero-latency combinational output Y driven by a 3-bit select split across S2/S1/S0.
- Also provides a registered copy Y_q, one clock later, for pipelined or timing-closed consumers.
- Single clock domain; synchronous active-high reset affects only the registered outputs.

Parameters:
- WIDTH, 16, bit width of every data input and of Y/Y_q.

Ports:
- clk  input  1  system clock; all registers update on its rising edge.
- rst  input  1  synchronous, active-high reset; sampled only on the rising edge of clk.
- I0  input  WIDTH  data input, selected when {S2,S1,S0}=3'b000.
- I1  input  WIDTH  data input, selected when {S2,S1,S0}=3'b001.
- I2  input  WIDTH  data input, selected when {S2,S1,S0}=3'b010.
- I3  input  WIDTH  data input, selected when {S2,S1,S0}=3'b011.
- I4  input  WIDTH  data input, selected when {S2,S1,S0}=3'b100.
- I5  input  WIDTH  data input, selected when {S2,S1,S0}=3'b101.
- I6  input  WIDTH  data input, selected when {S2,S1,S0}=3'b110.
- I7  input  WIDTH  data input, selected when {S2,S1,S0}=3'b111.
- S0  input  1  select bit 0 (LSB).
- S1  input  1  select bit 1.
- S2  input  1  select bit 2 (MSB).
- Y  output  WIDTH  combinational selected word.
- Y_q  output  WIDTH  registered selected word.

Behaviour:
- Select index: sel = {S2,S1,S0}, unsigned 0..7.
- Y = I[sel], purely combinational:
  - No clock dependency; Y is valid after propagation delay only.
  - Y is unaffected by rst.
  - All 8 encodings are legal; there is no default or invalid case.
- Y_q, on each rising clk edge:
  - If rst=1: Y_q <= 0.
  - Else: Y_q <= Y.
  - Latency is exactly one cycle from a select or data change to Y_q.
- Reset mid-operation: Y_q clears on the next edge while rst is high; Y keeps tracking inputs throughout.
- The first edge after rst deasserts loads the current Y.
- Data and select changes within a cycle: only the values present at the edge are captured; no glitch propagates to Y_q.
- X/Z handling: an X on any select bit may give X on Y. The implementation must not latch; no inferred latches are allowed.
- Data is passed bit-exact: no sign or zero extension, no arithmetic.

Optional Feature:
- Macro: MUX_SEL_ONEHOT_EN.
- When defined:
  - Adds output sel_oh, 8 bits, registered.
  - On each edge: sel_oh <= (1 << sel); reset value is 8'h00.
  - sel_oh has the same one-cycle latency as Y_q, so it is aligned with Y_q for datapath debug and bypass logic.
- When undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Shared package mux16b_pkg holds:
  - constant WORD_W = 16;
  - typedef word_t = logic [WORD_W-1:0];
  - select encodings SEL_I0..SEL_I7 = 3'd0..3'd7.
- Natural sub-module: mux16b_2to1, a WIDTH-wide 2:1 mux.
  - Seven instances form a 3-level tree: S0 at the leaves, S1 at the middle level, S2 at the root.
  - The output register sits in the top level.

Test Plan:
- Load I0..I7 = 5, 29, 38, 51, 64, 82, 94, 112 and sweep sel 0..7 with 10 ns steps. Y must equal 5, 29, 38, 51, 64, 82, 94, 112 respectively, with no clock required.
- Same inputs with a clock running and sel stepped once per cycle: Y_q lags Y by exactly one cycle. With MUX_SEL_ONEHOT_EN, sel_oh equals 8'h01, 8'h02, ..., 8'h80 aligned with Y_q.
- Assert rst for 2 cycles with sel=7: Y_q=0 (and sel_oh=0 if enabled) while Y=112. Deassert rst: on the next edge Y_q=112.
- Walking-ones data: I_k = 16'h0001 << k, with sel=k. Y must show a single set bit at position k, confirming bit-exact routing and no cross-talk. Also drive I_k=16'hFFFF with all other inputs 0.
- Change I3 from 16'h1234 to 16'hBEEF mid-cycle with sel=3: Y follows immediately; Y_q captures only the value present at the next edge.
- Assert rst mid-stream while sel changes every cycle: Y_q stays 0 for every edge with rst high and resumes correct tracking on the first edge after release.

Source files
------------

// File: rtl/mux16b_pkg.sv
// -----------------------------------------------------------------------------
// mux16b_pkg
// Shared definitions for the 16-bit 8:1 word multiplexer slice.
//   WORD_W        : native datapath word width
//   word_t        : one datapath word
//   SEL_I0..I7    : select encodings {S2,S1,S0} for each data input
//   sel_onehot()  : 3-bit select -> 8-bit one-hot
// -----------------------------------------------------------------------------
package mux16b_pkg;

   localparam int WORD_W = 16;

   typedef logic [WORD_W-1:0] word_t;

   localparam logic [2:0] SEL_I0 = 3'd0;
   localparam logic [2:0] SEL_I1 = 3'd1;
   localparam logic [2:0] SEL_I2 = 3'd2;
   localparam logic [2:0] SEL_I3 = 3'd3;
   localparam logic [2:0] SEL_I4 = 3'd4;
   localparam logic [2:0] SEL_I5 = 3'd5;
   localparam logic [2:0] SEL_I6 = 3'd6;
   localparam logic [2:0] SEL_I7 = 3'd7;

   function automatic logic [7:0] sel_onehot(input logic [2:0] sel);
      sel_onehot = 8'h01 << sel;
   endfunction

endpackage

// File: rtl/mux16b_2to1.sv
// -----------------------------------------------------------------------------
// mux16b_2to1
// WIDTH-wide 2:1 multiplexer, the leaf cell of the 8:1 tree.
//   d0 : selected when s = 0
//   d1 : selected when s = 1
//   s  : select
//   y  : selected word (combinational)
// -----------------------------------------------------------------------------
module mux16b_2to1
   import mux16b_pkg::*;
#(
   parameter int WIDTH = WORD_W
) (
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   input  logic             s,
   output logic [WIDTH-1:0] y
);

   assign y = s ? d1 : d0;

endmodule

// File: rtl/mux16b_8to1_sync.sv
// -----------------------------------------------------------------------------
// mux16b_8to1_sync
// 8-input word multiplexer with a combinational output and a registered copy.
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset, clears registered outputs only
//   I0..I7   : data inputs, I[k] selected when {S2,S1,S0} = k
//   S0/S1/S2 : select bits, S0 is the LSB
//   Y        : combinational selected word
//   Y_q      : Y registered one clock later
//   sel_oh   : registered one-hot of the select, aligned with Y_q
//              (only present when MUX_SEL_ONEHOT_EN is defined)
// Build option: MUX_SEL_ONEHOT_EN
// -----------------------------------------------------------------------------
module mux16b_8to1_sync
   import mux16b_pkg::*;
#(
   parameter int WIDTH = WORD_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] I0,
   input  logic [WIDTH-1:0] I1,
   input  logic [WIDTH-1:0] I2,
   input  logic [WIDTH-1:0] I3,
   input  logic [WIDTH-1:0] I4,
   input  logic [WIDTH-1:0] I5,
   input  logic [WIDTH-1:0] I6,
   input  logic [WIDTH-1:0] I7,
   input  logic             S0,
   input  logic             S1,
   input  logic             S2,
   output logic [WIDTH-1:0] Y,
   output logic [WIDTH-1:0] Y_q
`ifdef MUX_SEL_ONEHOT_EN
   ,
   output logic [7:0]       sel_oh
`endif
);

   // Tree levels: 8 leaves -> 4 -> 2 -> 1. S0 resolves adjacent pairs,
   // S1 pairs of pairs, S2 picks the half at the root.
   logic [7:0][WIDTH-1:0] din;
   logic [3:0][WIDTH-1:0] lvl1;
   logic [1:0][WIDTH-1:0] lvl2;

   assign din = {I7, I6, I5, I4, I3, I2, I1, I0};

   genvar g;
   for (g = 0; g < 4; g++) begin : g_leaf
      mux16b_2to1 #(.WIDTH(WIDTH)) u_mux (
         .d0 (din[2*g]),
         .d1 (din[2*g+1]),
         .s  (S0),
         .y  (lvl1[g])
      );
   end

   for (g = 0; g < 2; g++) begin : g_mid
      mux16b_2to1 #(.WIDTH(WIDTH)) u_mux (
         .d0 (lvl1[2*g]),
         .d1 (lvl1[2*g+1]),
         .s  (S1),
         .y  (lvl2[g])
      );
   end

   mux16b_2to1 #(.WIDTH(WIDTH)) u_root (
      .d0 (lvl2[0]),
      .d1 (lvl2[1]),
      .s  (S2),
      .y  (Y)
   );

   // Registered copy; only edge-time values are captured, so any
   // mid-cycle glitch on the tree never reaches Y_q.
   always_ff @(posedge clk) begin
      if (rst) Y_q <= '0;
      else     Y_q <= Y;
   end

`ifdef MUX_SEL_ONEHOT_EN
   always_ff @(posedge clk) begin
      if (rst) sel_oh <= 8'h00;
      else     sel_oh <= sel_onehot({S2, S1, S0});
   end
`endif

endmodule

// File: tb/tb_mux16b_8to1_sync.sv
module tb_mux16b_8to1_sync;
   import mux16b_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] din [8];
   logic [2:0]  sel = 3'd0;
   logic [15:0] Y, Y_q;
`ifdef MUX_SEL_ONEHOT_EN
   logic [7:0]  sel_oh;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Hand-loaded reference table for the basic sweep.
   logic [15:0] vals [8];

   always #5 clk = ~clk;

   mux16b_8to1_sync #(.WIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .I0  (din[0]),
      .I1  (din[1]),
      .I2  (din[2]),
      .I3  (din[3]),
      .I4  (din[4]),
      .I5  (din[5]),
      .I6  (din[6]),
      .I7  (din[7]),
      .S0  (sel[0]),
      .S1  (sel[1]),
      .S2  (sel[2]),
      .Y   (Y),
      .Y_q (Y_q)
`ifdef MUX_SEL_ONEHOT_EN
      ,
      .sel_oh (sel_oh)
`endif
   );

   task automatic load_vals();
      vals[0] = 16'd5;  vals[1] = 16'd29; vals[2] = 16'd38; vals[3] = 16'd51;
      vals[4] = 16'd64; vals[5] = 16'd82; vals[6] = 16'd94; vals[7] = 16'd112;
      for (int i = 0; i < 8; i++) din[i] = vals[i];
   endtask

   // Advance to 1 ns past the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      load_vals();
      rst = 1'b1;
      sel = 3'd2;
      tick();
      tick();
      n_checks++;
      if (Y_q !== 16'h0000) begin
         $display("FAIL reset_yq: got %h want %h", Y_q, 16'h0000); n_fail++;
      end
      n_checks++;
      if (Y !== 16'd38) begin
         $display("FAIL reset_y: got %0d want %0d", Y, 38); n_fail++;
      end
`ifdef MUX_SEL_ONEHOT_EN
      n_checks++;
      if (sel_oh !== 8'h00) begin
         $display("FAIL reset_seloh: got %h want %h", sel_oh, 8'h00); n_fail++;
      end
`endif
   endtask

   task automatic test_comb_sweep();
      logic [15:0] exp_y [8];
      exp_y[0] = 16'd5;  exp_y[1] = 16'd29; exp_y[2] = 16'd38; exp_y[3] = 16'd51;
      exp_y[4] = 16'd64; exp_y[5] = 16'd82; exp_y[6] = 16'd94; exp_y[7] = 16'd112;
      load_vals();
      rst = 1'b1;
      for (int k = 0; k < 8; k++) begin
         sel = 3'(k);
         #10;
         n_checks++;
         if (Y !== exp_y[k]) begin
            $display("FAIL comb_sweep sel=%0d: got %0d want %0d", k, Y, exp_y[k]); n_fail++;
         end
      end
   endtask

   task automatic test_registered();
      load_vals();
      rst = 1'b1;
      sel = 3'd0;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         sel = 3'(k);
         #1;
         if (k > 0) begin
            n_checks++;
            if (Y_q !== vals[k-1]) begin
               $display("FAIL reg_lag k=%0d: got %0d want %0d", k, Y_q, vals[k-1]); n_fail++;
            end
         end
         tick();
         n_checks++;
         if (Y_q !== vals[k]) begin
            $display("FAIL reg_yq k=%0d: got %0d want %0d", k, Y_q, vals[k]); n_fail++;
         end
`ifdef MUX_SEL_ONEHOT_EN
         n_checks++;
         if (sel_oh !== (8'h01 << k)) begin
            $display("FAIL reg_seloh k=%0d: got %h want %h", k, sel_oh, 8'h01 << k); n_fail++;
         end
`endif
      end
   endtask

   task automatic test_reset_hold();
      load_vals();
      sel = SEL_I7;
      rst = 1'b1;
      for (int c = 0; c < 2; c++) begin
         tick();
         n_checks++;
         if (Y_q !== 16'h0000) begin
            $display("FAIL hold_yq c=%0d: got %0d want 0", c, Y_q); n_fail++;
         end
         n_checks++;
         if (Y !== 16'd112) begin
            $display("FAIL hold_y c=%0d: got %0d want 112", c, Y); n_fail++;
         end
`ifdef MUX_SEL_ONEHOT_EN
         n_checks++;
         if (sel_oh !== 8'h00) begin
            $display("FAIL hold_seloh c=%0d: got %h want 00", c, sel_oh); n_fail++;
         end
`endif
      end
      rst = 1'b0;
      tick();
      n_checks++;
      if (Y_q !== 16'd112) begin
         $display("FAIL hold_release: got %0d want 112", Y_q); n_fail++;
      end
   endtask

   task automatic test_walking_ones();
      logic [15:0] pat [2];
      pat[0] = 16'h0001;
      pat[1] = 16'hFFFF;
      for (int p = 0; p < 2; p++) begin
         for (int k = 0; k < 8; k++) begin
            logic [15:0] w;
            w = (p == 0) ? (pat[0] << k) : pat[1];
            for (int i = 0; i < 8; i++) din[i] = 16'h0000;
            din[k] = w;
            sel = 3'(k);
            #1;
            n_checks++;
            if (Y !== w) begin
               $display("FAIL walk p=%0d k=%0d: got %h want %h", p, k, Y, w); n_fail++;
            end
            // A neighbouring select must see nothing of the active input.
            sel = 3'((k + 1) % 8);
            #1;
            n_checks++;
            if (Y !== 16'h0000) begin
               $display("FAIL walk_xtalk p=%0d k=%0d: got %h want 0000", p, k, Y); n_fail++;
            end
         end
      end
   endtask

   task automatic test_midcycle();
      load_vals();
      rst = 1'b0;
      sel = SEL_I3;
      din[3] = 16'h1234;
      tick();
      n_checks++;
      if (Y_q !== 16'h1234) begin
         $display("FAIL mid_first: got %h want 1234", Y_q); n_fail++;
      end
      #1;
      din[3] = 16'hBEEF;
      #1;
      n_checks++;
      if (Y !== 16'hBEEF) begin
         $display("FAIL mid_y: got %h want beef", Y); n_fail++;
      end
      n_checks++;
      if (Y_q !== 16'h1234) begin
         $display("FAIL mid_yq_held: got %h want 1234", Y_q); n_fail++;
      end
      tick();
      n_checks++;
      if (Y_q !== 16'hBEEF) begin
         $display("FAIL mid_yq_new: got %h want beef", Y_q); n_fail++;
      end
   endtask

   task automatic test_reset_midstream();
      logic [15:0] exp_q;
      load_vals();
      for (int i = 0; i < 10; i++) begin
         sel = 3'((i * 3) % 8);
         rst = (i >= 3 && i <= 5);
         exp_q = rst ? 16'h0000 : vals[(i * 3) % 8];
         tick();
         n_checks++;
         if (Y_q !== exp_q) begin
            $display("FAIL midrst i=%0d: got %0d want %0d", i, Y_q, exp_q); n_fail++;
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 8; i++) din[i] = 16'h0000;
      #1;
      test_reset();
      test_comb_sweep();
      test_registered();
      test_reset_hold();
      test_walking_ones();
      test_midcycle();
      test_reset_midstream();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
